// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures the period, high time and 10-bit duty of an asynchronous PWM input.
// Duty comes from an 11-step restoring divider; a stuck input is reported after TIMEOUT cycles.
module pwm_duty_meter #(
  parameter logic [31:0] TIMEOUT = 32'd200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwm_in,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic [9:0]  duty,
  output logic        valid,
  output logic        stuck,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        sync_ff, s, s_d;
  logic        rise, fall;
  logic [31:0] cnt, cnt_inc, hcnt;
  logic        timeout, start, close, load;

  logic        busy;
  logic [3:0]  step;
  logic [31:0] div_p, div_h, rem;
  logic [10:0] dsr;
  logic [9:0]  quo;
  logic [32:0] rem_sh, rem_diff;
  logic        q_bit, last, free;
  logic [10:0] quo_nxt;

  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign cnt_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  assign timeout = (state != IDLE) && !rise && (cnt == TIMEOUT - 32'd1);
  assign start   = (state == IDLE) && rise;
  assign close   = (state == LOW) && rise;

  // One restoring step: shift the next dividend bit in, subtract when the borrow is clear.
  assign rem_sh   = {rem, dsr[10]};
  assign rem_diff = rem_sh - {1'b0, div_p};
  assign q_bit    = ~rem_diff[32];
  assign quo_nxt  = {quo, q_bit};
  assign last     = busy && (step == 4'd1);
  assign free     = !busy || last;
  assign load     = close && free;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = HIGH;
      HIGH:    if (timeout) state_nxt = IDLE;
               else if (fall) state_nxt = LOW;
      LOW:     if (rise) state_nxt = HIGH;
               else if (timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_ff   <= 1'b0;
      s         <= 1'b0;
      s_d       <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      busy      <= 1'b0;
      step      <= '0;
      div_p     <= '0;
      div_h     <= '0;
      rem       <= '0;
      dsr       <= '0;
      quo       <= '0;
      period    <= '0;
      high_time <= '0;
      duty      <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sync_ff <= pwm_in;
      s       <= sync_ff;
      s_d     <= s;
      state   <= state_nxt;
      valid   <= 1'b0;
      overrun <= close && !free;

      if (rise || state_nxt == IDLE) cnt <= '0;
      else                           cnt <= cnt_inc;

      if (state == HIGH && fall) hcnt <= cnt_inc;

      if (timeout) begin
        busy      <= 1'b0;
        stuck     <= 1'b1;
        period    <= '0;
        high_time <= '0;
        duty      <= s ? 10'h3FF : 10'h000;
        valid     <= 1'b1;
      end else begin
        if (busy) begin
          rem  <= q_bit ? rem_diff[31:0] : rem_sh[31:0];
          dsr  <= {dsr[9:0], 1'b0};
          quo  <= quo_nxt[9:0];
          step <= step - 4'd1;
        end
        if (last) begin
          busy      <= 1'b0;
          period    <= div_p;
          high_time <= div_h;
          duty      <= quo_nxt[10] ? 10'h3FF : quo_nxt[9:0];
          valid     <= 1'b1;
        end
        // h <= p, so the quotient bits above bit 10 are zero and h>>1 is the starting remainder.
        if (load) begin
          busy  <= 1'b1;
          step  <= 4'd11;
          div_p <= cnt_inc;
          div_h <= hcnt;
          rem   <= {1'b0, hcnt[31:1]};
          dsr   <= {hcnt[0], 10'b0};
          quo   <= '0;
        end
        if (start) stuck <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: directed and random PWM segments scored against an
// edge-timestamp model (period/high from edge spacing, duty by plain integer arithmetic).
module tb_pwm_duty_meter;

  localparam int unsigned TO = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [31:0] period, high_time;
  logic [9:0]  duty;
  logic        valid, stuck, overrun;

  pwm_duty_meter #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (pwm_in),
    .period   (period),
    .high_time(high_time),
    .duty     (duty),
    .valid    (valid),
    .stuck    (stuck),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int unsigned stamp;
    logic [31:0] per;
    logic [31:0] hi;
    logic [9:0]  dut_duty;
    logic        stk;
  } ev_t;

  ev_t         exp_q[$], obs_q[$];
  int unsigned exp_ov[$], obs_ov[$];
  int          errors = 0;
  int          checks = 0;

  // Observed events, stamped with the cycle in which the pulse is high.
  always @(negedge clk) begin
    if (valid) obs_q.push_back(ev_t'{cyc, period, high_time, duty, stuck});
    if (overrun) obs_ov.push_back(cyc);
  end

  // Model state: edge stamps are the cycle at which pwm_in was driven.
  bit          in_meas = 1'b0;
  bit          has_fall = 1'b0;
  int unsigned last_rise = 0, last_fall = 0, div_free_at = 0;

  function automatic logic [9:0] model_duty(int unsigned h, int unsigned p);
    longint unsigned q;
    q = (longint'(h) * 1024) / longint'(p);
    return (q > 1023) ? 10'd1023 : q[9:0];
  endfunction

  function automatic void push_timeout();
    bit lvl;
    lvl = !(has_fall && (last_fall - last_rise <= TO));
    exp_q.push_back(ev_t'{last_rise + TO + 3, 32'd0, 32'd0, lvl ? 10'd1023 : 10'd0, 1'b1});
    in_meas = 1'b0;
  endfunction

  function automatic void model_flush(int unsigned now);
    if (in_meas && (now - last_rise > TO)) push_timeout();
  endfunction

  function automatic void model_edge(bit lvl, int unsigned e);
    int unsigned p, h;
    model_flush(e);
    if (lvl) begin
      if (in_meas) begin
        p = e - last_rise;
        h = last_fall - last_rise;
        if (e >= div_free_at) begin
          exp_q.push_back(ev_t'{e + 14, p, h, model_duty(h, p), 1'b0});
          div_free_at = e + 11;
        end else begin
          exp_ov.push_back(e + 3);
        end
      end
      in_meas   = 1'b1;
      last_rise = e;
      has_fall  = 1'b0;
    end else if (in_meas) begin
      last_fall = e;
      has_fall  = 1'b1;
    end
  endfunction

  function automatic void model_reset(int unsigned now);
    ev_t         keep[$];
    int unsigned keep_ov[$];
    foreach (exp_q[i]) if (exp_q[i].stamp <= now) keep.push_back(exp_q[i]);
    foreach (exp_ov[i]) if (exp_ov[i] <= now) keep_ov.push_back(exp_ov[i]);
    exp_q       = keep;
    exp_ov      = keep_ov;
    in_meas     = 1'b0;
    has_fall    = 1'b0;
    div_free_at = 0;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive a level for n cycles; a change of level is an edge for the model.
  task automatic seg(input bit lvl, input int unsigned n);
    @(negedge clk);
    if (pwm_in !== lvl) begin
      pwm_in = lvl;
      model_edge(lvl, cyc);
    end
    repeat (n - 1) @(negedge clk);
  endtask

  // Pair every expected and observed event that is already in the past.
  task automatic compare();
    ev_t         e, o;
    int unsigned eo, oo;
    bit          he, ho;
    model_flush(cyc);
    while (1) begin
      he = (exp_q.size() > 0) && (exp_q[0].stamp < cyc);
      ho = (obs_q.size() > 0) && (obs_q[0].stamp < cyc);
      if (!he && !ho) break;
      e = '0;
      o = '0;
      if (he) e = exp_q.pop_front();
      if (ho) o = obs_q.pop_front();
      check("valid_event", o, e);
    end
    while (1) begin
      he = (exp_ov.size() > 0) && (exp_ov[0] < cyc);
      ho = (obs_ov.size() > 0) && (obs_ov[0] < cyc);
      if (!he && !ho) break;
      eo = 0;
      oo = 0;
      if (he) eo = exp_ov.pop_front();
      if (ho) oo = obs_ov.pop_front();
      check("overrun_event", oo, eo);
    end
  endtask

  int unsigned p, h;

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      pwm_in = ~pwm_in;
    end
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_duty", duty, 0);
    check("rst_flags", {valid, stuck, overrun}, 0);
    @(negedge clk);
    pwm_in = 1'b0;
    rst    = 1'b0;
    model_reset(cyc);
    repeat (20) @(negedge clk);
    check("post_rst_valid", valid, 0);
    compare();

    // Nominal 25 kHz at duty 800, then near-full duty, then constant low into timeout.
    for (int i = 0; i < 5; i++) begin
      seg(1'b1, 3125);
      seg(1'b0, 875);
    end
    for (int i = 0; i < 4; i++) begin
      seg(1'b1, 3996);
      seg(1'b0, 4);
    end
    seg(1'b0, TO + 20);
    check("low_stuck", stuck, 1);
    check("low_duty", duty, 0);
    check("low_period", period, 0);
    compare();

    // Stuck high, then a clean PWM clears stuck on its first rise.
    seg(1'b1, TO + 10);
    check("high_stuck", stuck, 1);
    check("high_duty", duty, 10'd1023);
    check("high_period", period, 0);
    check("high_high_time", high_time, 0);
    compare();
    seg(1'b0, 50);
    seg(1'b1, 3);
    check("stuck_before_clear", stuck, 1);
    seg(1'b1, 1);
    check("stuck_cleared", stuck, 0);
    seg(1'b1, 7);
    seg(1'b0, 29);
    for (int i = 0; i < 3; i++) begin
      seg(1'b1, 11);
      seg(1'b0, 29);
    end
    compare();

    // Period 8 is shorter than the divider latency: every other closing rise overruns.
    for (int i = 0; i < 8; i++) begin
      seg(1'b1, 4);
      seg(1'b0, 4);
    end
    seg(1'b0, 30);
    compare();

    // Random periods, some short enough to overrun.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(3, 0) == 0) p = $urandom_range(10, 4);
      else                           p = $urandom_range(300, 16);
      h = $urandom_range(p - 1, 1);
      seg(1'b1, h);
      seg(1'b0, p - h);
    end
    seg(1'b0, 20);
    compare();

    // Reset five cycles after a closing rise abandons the division.
    seg(1'b1, 30);
    seg(1'b0, 70);
    seg(1'b1, 8);
    rst    = 1'b1;
    pwm_in = 1'b0;
    model_reset(cyc);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("mid_rst_period", period, 0);
    check("mid_rst_duty", duty, 0);
    check("mid_rst_flags", {valid, stuck, overrun}, 0);
    compare();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
